// File: rtl/mii_rx_frame.sv
// MII receive framer: strips preamble/SFD, assembles nibbles into bytes and
// reports per-frame length and status (address filter, CRC-32, length, errors).
module mii_rx_frame #(
    parameter int MIN_FL = 64,
    parameter int MAX_FL = 1536
) (
    input  logic        MRxCLK,
    input  logic        prstn_i,
    input  logic        MRxDV,
    input  logic [3:0]  MRxD,
    input  logic        MRxErr,
    input  logic        HUGEN,
    input  logic        PRO,
    input  logic [47:0] MAC_ADDR,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_sof_o,
    output logic        rx_done_o,
    output logic [15:0] rx_len_o,
    output logic [5:0]  rx_status_o
);

    typedef enum logic [1:0] {IDLE, PREAM, DATA, DROP} state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [15:0] MIN_LEN     = 16'(MIN_FL);
    localparam logic [15:0] MAX_LEN     = 16'(MAX_FL);

    state_t      state, state_nx;
    logic        dv_q;
    logic        start;
    logic        phase;
    logic [3:0]  even;
    logic [15:0] cnt;
    logic [31:0] crc, crc_byte, crc_next;
    logic        err;
    logic        mac_ok, bc_ok;
    logic [7:0]  mac_byte;
    logic [7:0]  byte_in;
    logic        addr_miss;

    // MSB-first register fed LSB-first data bits: the bit-reversed view of the
    // usual reflected Ethernet CRC, hence the matching reversed residue.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            if (r[31] ^ d[i]) r = (r << 1) ^ 32'h04C11DB7;
            else              r = r << 1;
        end
        return r;
    endfunction

    assign start    = MRxDV & ~dv_q;
    assign byte_in  = {MRxD, even};
    assign crc_next = crc_nib(crc, MRxD);
    assign addr_miss = ~PRO & ((cnt < 16'd6) | ~(mac_ok | bc_ok));

    always_comb begin
        mac_byte = MAC_ADDR[47:40];
        case (cnt[2:0])
            3'd1:    mac_byte = MAC_ADDR[39:32];
            3'd2:    mac_byte = MAC_ADDR[31:24];
            3'd3:    mac_byte = MAC_ADDR[23:16];
            3'd4:    mac_byte = MAC_ADDR[15:8];
            3'd5:    mac_byte = MAC_ADDR[7:0];
            default: mac_byte = MAC_ADDR[47:40];
        endcase
    end

    always_ff @(posedge MRxCLK or negedge prstn_i) begin
        if (!prstn_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (MRxD == 4'h5)      state_nx = PREAM;
                    else if (MRxD == 4'hD) state_nx = DATA;
                    else                   state_nx = DROP;
                end
            end
            PREAM: begin
                if (!MRxDV)            state_nx = IDLE;
                else if (MRxD == 4'hD) state_nx = DATA;
                else if (MRxD != 4'h5) state_nx = DROP;
            end
            DATA:    if (!MRxDV) state_nx = IDLE;
            DROP:    if (!MRxDV) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // dv_q resets high so a frame already running at reset release is ignored.
    always_ff @(posedge MRxCLK or negedge prstn_i) begin
        if (!prstn_i) begin
            dv_q        <= 1'b1;
            phase       <= 1'b0;
            even        <= 4'h0;
            cnt         <= 16'h0;
            crc         <= 32'hFFFFFFFF;
            crc_byte    <= 32'hFFFFFFFF;
            err         <= 1'b0;
            mac_ok      <= 1'b0;
            bc_ok       <= 1'b0;
            rx_data_o   <= 8'h0;
            rx_valid_o  <= 1'b0;
            rx_sof_o    <= 1'b0;
            rx_done_o   <= 1'b0;
            rx_len_o    <= 16'h0;
            rx_status_o <= 6'h0;
        end else begin
            dv_q       <= MRxDV;
            rx_valid_o <= 1'b0;
            rx_sof_o   <= 1'b0;
            rx_done_o  <= 1'b0;
            if (state == DATA) begin
                if (MRxDV) begin
                    crc   <= crc_next;
                    phase <= ~phase;
                    if (MRxErr) err <= 1'b1;
                    if (!phase) begin
                        even <= MRxD;
                    end else begin
                        rx_valid_o <= 1'b1;
                        rx_data_o  <= byte_in;
                        rx_sof_o   <= (cnt == 16'h0);
                        crc_byte   <= crc_next;
                        if (cnt < 16'd6) begin
                            if (byte_in != mac_byte) mac_ok <= 1'b0;
                            if (byte_in != 8'hFF)    bc_ok  <= 1'b0;
                        end
                        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
                    end
                end else begin
                    // crc_byte excludes any dangling dribble nibble.
                    rx_done_o   <= 1'b1;
                    rx_len_o    <= cnt;
                    rx_status_o <= {addr_miss, crc_byte != CRC_RESIDUE,
                                    (cnt > MAX_LEN) & ~HUGEN, cnt < MIN_LEN,
                                    phase, err};
                end
            end else begin
                phase    <= 1'b0;
                cnt      <= 16'h0;
                crc      <= 32'hFFFFFFFF;
                crc_byte <= 32'hFFFFFFFF;
                err      <= 1'b0;
                mac_ok   <= 1'b1;
                bc_ok    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mii_rx_frame.sv
// Directed bench for mii_rx_frame: builds Ethernet frames with an independently
// computed reflected CRC-32 and checks strobes, length and status per scenario.
module tb_mii_rx_frame;

    localparam logic [47:0] MAC = 48'h001A2B3C4D5E;

    logic        clk = 1'b0;
    logic        prstn_i;
    logic        MRxDV;
    logic [3:0]  MRxD;
    logic        MRxErr;
    logic        HUGEN;
    logic        PRO;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_sof_o;
    logic        rx_done_o;
    logic [15:0] rx_len_o;
    logic [5:0]  rx_status_o;

    int checks = 0;
    int passed = 0;

    logic [7:0] frame[$];
    logic [7:0] exp_q[$];
    int         valid_cnt, sof_cnt, sof_first, data_bad, done_cnt;
    logic [15:0] last_len;
    logic [5:0]  last_stat, first_stat;

    always #5 clk = ~clk;

    mii_rx_frame dut (
        .MRxCLK(clk), .prstn_i(prstn_i), .MRxDV(MRxDV), .MRxD(MRxD),
        .MRxErr(MRxErr), .HUGEN(HUGEN), .PRO(PRO), .MAC_ADDR(MAC),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_sof_o(rx_sof_o),
        .rx_done_o(rx_done_o), .rx_len_o(rx_len_o), .rx_status_o(rx_status_o)
    );

    task automatic clear_capture();
        valid_cnt = 0; sof_cnt = 0; sof_first = 0; data_bad = 0; done_cnt = 0;
        last_len = 16'h0; last_stat = 6'h0; first_stat = 6'h0;
        exp_q.delete();
    endtask

    // Drive one MII cycle, then observe the registered outputs 1 ns after the edge.
    task automatic step(input logic dv, input logic [3:0] d, input logic err);
        logic [7:0] e;
        MRxDV = dv; MRxD = d; MRxErr = err;
        @(posedge clk); #1;
        if (rx_valid_o === 1'b1) begin
            valid_cnt++;
            if (rx_sof_o === 1'b1) begin
                sof_cnt++;
                if (valid_cnt == 1) sof_first = 1;
            end
            if (exp_q.size() == 0) data_bad++;
            else begin
                e = exp_q.pop_front();
                if (e !== rx_data_o) data_bad++;
            end
        end
        if (rx_done_o === 1'b1) begin
            done_cnt++;
            if (done_cnt == 1) first_stat = rx_status_o;
            last_len  = rx_len_o;
            last_stat = rx_status_o;
        end
    endtask

    task automatic build_frame(input logic [47:0] da, input int len);
        logic [31:0] c;
        logic [7:0]  b;
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(8'(8'h10 + i));
        frame.push_back(8'h08);
        frame.push_back(8'h00);
        for (int i = 0; i < len - 18; i++) frame.push_back(8'(i * 7 + 3));
        c = 32'hFFFFFFFF;
        foreach (frame[i]) begin
            c = c ^ {24'h0, frame[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) begin
            b = c[8*i +: 8];
            frame.push_back(b);
        end
    endtask

    task automatic send_frame(input int npre, input logic extra, input int err_at, input int gap);
        int idx;
        foreach (frame[i]) exp_q.push_back(frame[i]);
        for (int i = 0; i < npre; i++) step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'hD, 1'b0);
        idx = 0;
        foreach (frame[i]) begin
            step(1'b1, frame[i][3:0], idx == err_at); idx++;
            step(1'b1, frame[i][7:4], idx == err_at); idx++;
        end
        if (extra) step(1'b1, 4'hA, 1'b0);
        for (int i = 0; i < gap; i++) step(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_reset();
        prstn_i = 1'b0; MRxDV = 1'b0; MRxD = 4'h0; MRxErr = 1'b0; HUGEN = 1'b0; PRO = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({rx_valid_o, rx_sof_o, rx_done_o} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {rx_valid_o, rx_sof_o, rx_done_o}); else passed++;
        checks++; if ({rx_data_o, rx_len_o, rx_status_o} !== 30'h0) $display("FAIL reset_regs got %h want 0", {rx_data_o, rx_len_o, rx_status_o}); else passed++;
        prstn_i = 1'b1;
        repeat (3) step(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_good_frame();
        clear_capture(); build_frame(MAC, 64); send_frame(14, 1'b0, -1, 4);
        checks++; if (valid_cnt !== 64) $display("FAIL good_valid_cnt got %0d want 64", valid_cnt); else passed++;
        checks++; if (sof_cnt !== 1 || sof_first !== 1) $display("FAIL good_sof got cnt=%0d first=%0d want 1/1", sof_cnt, sof_first); else passed++;
        checks++; if (data_bad !== 0) $display("FAIL good_data got %0d bad bytes want 0", data_bad); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL good_done_cnt got %0d want 1", done_cnt); else passed++;
        checks++; if (last_len !== 16'd64) $display("FAIL good_len got %0d want 64", last_len); else passed++;
        checks++; if (last_stat !== 6'b000000) $display("FAIL good_status got %b want 000000", last_stat); else passed++;
        checks++; if (rx_len_o !== 16'd64 || rx_status_o !== 6'b000000) $display("FAIL good_held got %0d/%b want 64/000000", rx_len_o, rx_status_o); else passed++;
    endtask

    task automatic test_crc_error();
        clear_capture(); build_frame(MAC, 64); frame[30] = frame[30] ^ 8'h04;
        send_frame(14, 1'b0, -1, 4);
        checks++; if (last_len !== 16'd64) $display("FAIL crc_len got %0d want 64", last_len); else passed++;
        checks++; if (last_stat !== 6'b010000) $display("FAIL crc_status got %b want 010000", last_stat); else passed++;
    endtask

    task automatic test_broadcast_short();
        clear_capture(); build_frame(48'hFFFFFFFFFFFF, 60); send_frame(14, 1'b0, -1, 4);
        checks++; if (last_len !== 16'd60) $display("FAIL bcast_len got %0d want 60", last_len); else passed++;
        checks++; if (last_stat !== 6'b000100) $display("FAIL bcast_status got %b want 000100", last_stat); else passed++;
    endtask

    task automatic test_long();
        HUGEN = 1'b0; clear_capture(); build_frame(MAC, 1600); send_frame(14, 1'b0, -1, 4);
        checks++; if (last_len !== 16'd1600) $display("FAIL long_len got %0d want 1600", last_len); else passed++;
        checks++; if (last_stat !== 6'b001000) $display("FAIL long_status_hugen0 got %b want 001000", last_stat); else passed++;
        HUGEN = 1'b1; clear_capture(); send_frame(14, 1'b0, -1, 4);
        checks++; if (valid_cnt !== 1600) $display("FAIL long_valid_cnt got %0d want 1600", valid_cnt); else passed++;
        checks++; if (last_stat !== 6'b000000) $display("FAIL long_status_hugen1 got %b want 000000", last_stat); else passed++;
        HUGEN = 1'b0;
    endtask

    task automatic test_addr_filter();
        PRO = 1'b0; clear_capture(); build_frame(48'h001A2B3C4D5F, 64); send_frame(14, 1'b0, -1, 4);
        checks++; if (last_stat !== 6'b100000) $display("FAIL addr_miss_pro0 got %b want 100000", last_stat); else passed++;
        PRO = 1'b1; clear_capture(); send_frame(14, 1'b0, -1, 4);
        checks++; if (last_stat !== 6'b000000) $display("FAIL addr_miss_pro1 got %b want 000000", last_stat); else passed++;
        PRO = 1'b0;
    endtask

    task automatic test_dribble();
        clear_capture(); build_frame(MAC, 64); send_frame(14, 1'b1, -1, 4);
        checks++; if (valid_cnt !== 64) $display("FAIL dribble_valid_cnt got %0d want 64", valid_cnt); else passed++;
        checks++; if (last_len !== 16'd64) $display("FAIL dribble_len got %0d want 64", last_len); else passed++;
        checks++; if (last_stat !== 6'b000010) $display("FAIL dribble_status got %b want 000010", last_stat); else passed++;
    endtask

    task automatic test_rx_err();
        clear_capture(); build_frame(MAC, 64); send_frame(14, 1'b0, 40, 4);
        checks++; if (last_stat !== 6'b000001) $display("FAIL rxerr_status got %b want 000001", last_stat); else passed++;
        checks++; if (data_bad !== 0) $display("FAIL rxerr_data got %0d bad bytes want 0", data_bad); else passed++;
    endtask

    task automatic test_no_preamble();
        clear_capture(); build_frame(MAC, 64); send_frame(0, 1'b0, -1, 4);
        checks++; if (done_cnt !== 1 || last_len !== 16'd64) $display("FAIL nopre_done got %0d/%0d want 1/64", done_cnt, last_len); else passed++;
        checks++; if (last_stat !== 6'b000000) $display("FAIL nopre_status got %b want 000000", last_stat); else passed++;
    endtask

    task automatic test_preamble_abort_and_drop();
        clear_capture();
        repeat (6) step(1'b1, 4'h5, 1'b0);
        repeat (3) step(1'b0, 4'h0, 1'b0);
        checks++; if (done_cnt !== 0 || valid_cnt !== 0) $display("FAIL pream_abort got done=%0d valid=%0d want 0/0", done_cnt, valid_cnt); else passed++;
        step(1'b1, 4'h3, 1'b0);
        repeat (3) step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 4'(i), 1'b0);
        repeat (3) step(1'b0, 4'h0, 1'b0);
        checks++; if (done_cnt !== 0 || valid_cnt !== 0) $display("FAIL drop got done=%0d valid=%0d want 0/0", done_cnt, valid_cnt); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        clear_capture(); build_frame(MAC, 64);
        repeat (7) step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, frame[i][3:0], 1'b0);
            step(1'b1, frame[i][7:4], 1'b0);
        end
        prstn_i = 1'b0;
        step(1'b1, frame[20][3:0], 1'b0);
        step(1'b1, frame[20][7:4], 1'b0);
        prstn_i = 1'b1;
        clear_capture();
        for (int i = 21; i < 64; i++) begin
            step(1'b1, frame[i][3:0], 1'b0);
            step(1'b1, frame[i][7:4], 1'b0);
        end
        repeat (4) step(1'b0, 4'h0, 1'b0);
        checks++; if (done_cnt !== 0) $display("FAIL rstmid_done got %0d want 0", done_cnt); else passed++;
        checks++; if (valid_cnt !== 0) $display("FAIL rstmid_valid got %0d want 0", valid_cnt); else passed++;
        checks++; if (rx_len_o !== 16'd0 || rx_status_o !== 6'd0) $display("FAIL rstmid_held got %0d/%b want 0/000000", rx_len_o, rx_status_o); else passed++;
        clear_capture(); send_frame(14, 1'b0, -1, 4);
        checks++; if (done_cnt !== 1 || last_len !== 16'd64) $display("FAIL rstmid_next got %0d/%0d want 1/64", done_cnt, last_len); else passed++;
        checks++; if (last_stat !== 6'b000000 || data_bad !== 0) $display("FAIL rstmid_next_status got %b bad=%0d want 000000/0", last_stat, data_bad); else passed++;
    endtask

    task automatic test_back_to_back();
        clear_capture();
        build_frame(MAC, 64); send_frame(14, 1'b0, -1, 1);
        build_frame(MAC, 64); frame[40] = frame[40] ^ 8'h80; send_frame(14, 1'b0, -1, 4);
        checks++; if (done_cnt !== 2) $display("FAIL b2b_done_cnt got %0d want 2", done_cnt); else passed++;
        checks++; if (first_stat !== 6'b000000 || last_stat !== 6'b010000) $display("FAIL b2b_status got %b,%b want 000000,010000", first_stat, last_stat); else passed++;
        checks++; if (valid_cnt !== 128 || data_bad !== 0) $display("FAIL b2b_bytes got %0d bad=%0d want 128/0", valid_cnt, data_bad); else passed++;
    endtask

    initial begin
        clear_capture();
        test_reset();
        test_good_frame();
        test_crc_error();
        test_broadcast_short();
        test_long();
        test_addr_filter();
        test_dribble();
        test_rx_err();
        test_no_preamble();
        test_preamble_abort_and_drop();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mii_rx_frame.md
MII_RX_FRAME -- requirements
Module: mii_rx_frame

Interface
REQ-001 SHALL have parameter MIN_FL, default 64, minimum legal frame length in bytes (DA through CRC).
REQ-002 SHALL have parameter MAX_FL, default 1536, maximum legal frame length in bytes when HUGEN=0.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port MRxCLK  input  1  receive clock; all logic on rising edge.
REQ-005 SHALL have port prstn_i  input  1  asynchronous active-low reset.
REQ-006 SHALL have port MRxDV  input  1  receive data valid.
REQ-007 SHALL have port MRxD  input  4  receive nibble; low nibble of each byte first.
REQ-008 SHALL have port MRxErr  input  1  PHY receive error.
REQ-009 SHALL have port HUGEN  input  1  1 = no upper length limit.
REQ-010 SHALL have port PRO  input  1  1 = promiscuous mode (no address filtering).
REQ-011 SHALL have port MAC_ADDR  input  48  station address; first DA byte compares to MAC_ADDR[47:40].
REQ-012 SHALL have port rx_data_o  output  8  assembled byte.
REQ-013 SHALL have port rx_valid_o  output  1  rx_data_o valid, one-cycle strobe per byte.
REQ-014 SHALL have port rx_sof_o  output  1  high with rx_valid_o on the first DA byte.
REQ-015 SHALL have port rx_done_o  output  1  one-cycle end-of-frame pulse.
REQ-016 SHALL have port rx_len_o  output  16  byte count of the frame, held from rx_done_o until the next rx_done_o.
REQ-017 SHALL have port rx_status_o  output  6  {addr_miss, crc_err, too_long, too_short, dribble, rx_err}, held like rx_len_o.

Function
REQ-018 SHALL implement states IDLE, PREAM, DATA, DROP.
REQ-019 SHALL register MRxDV as dv_q; a start condition SHALL be MRxDV=1 and dv_q=0.
REQ-020 In IDLE, on start with MRxD=4'h5, SHALL go to PREAM.
REQ-021 In IDLE, on start with MRxD=4'hD, SHALL go to DATA (no-preamble case).
REQ-022 In IDLE, on start with any other MRxD, SHALL go to DROP.
REQ-023 In PREAM, MRxD=4'h5 SHALL stay in PREAM, MRxD=4'hD (SFD) SHALL go to DATA, and any other value SHALL go to DROP.
REQ-024 In PREAM, MRxDV=0 SHALL go to IDLE without a rx_done_o pulse.
REQ-025 DROP SHALL remain until MRxDV=0, then go to IDLE, with no outputs asserted.
REQ-026 In DATA, the nibble phase SHALL toggle each cycle: the even nibble is stored as byte[3:0], and the odd nibble completes the byte.
REQ-027 rx_valid_o SHALL assert exactly one cycle after the odd nibble is sampled, with rx_data_o = {odd, even}.
REQ-028 The byte counter SHALL increment per completed byte and saturate at 16'hFFFF.
REQ-029 CRC-32 (poly 0x04C11DB7, init all-ones, reflected, nibble-serial) SHALL run over every DATA nibble, including the FCS.
REQ-030 crc_err SHALL be set unless the final register equals residue 32'hC704DD7B.
REQ-031 Bytes 0..5 SHALL be compared against MAC_ADDR and against 48'hFFFFFFFFFFFF.
REQ-032 addr_miss SHALL be set when neither matches and PRO=0.
REQ-033 Frames shorter than 6 bytes SHALL set addr_miss when PRO=0.
REQ-034 MRxErr=1 on any DATA cycle SHALL set sticky rx_err for the frame.
REQ-035 DATA ends on the first cycle MRxDV=0; the SM SHALL then go to IDLE.
REQ-036 rx_done_o SHALL pulse on the cycle after DATA ends, with rx_len_o and rx_status_o updated in that same cycle.
REQ-037 On an odd nibble count, dribble SHALL be set, the partial byte SHALL be discarded with no rx_valid_o, and CRC SHALL be evaluated over whole bytes only.
REQ-038 too_short SHALL be set when the count is below MIN_FL.
REQ-039 too_long SHALL be set when the count exceeds MAX_FL and HUGEN=0.
REQ-040 A start in the same cycle as rx_done_o SHALL be accepted as a new frame; the held status SHALL update only at that frame's end.

Reset
REQ-041 On prstn_i=0, SHALL asynchronously set state=IDLE.
REQ-042 On prstn_i=0, SHALL asynchronously set all outputs, counters and flags to 0, and the CRC to all-ones.
REQ-043 On prstn_i=0, dv_q SHALL reset to 1, so a frame already in progress at reset release is ignored until MRxDV=0.
REQ-044 Reset asserted mid-frame SHALL abort the frame with no rx_done_o pulse.

Verification
REQ-045 Bench SHALL drive 14x5, D, a 64-byte frame with DA=MAC_ADDR and valid FCS -> 64 rx_valid_o pulses, rx_sof_o on the first, rx_done_o with rx_len_o=64 and rx_status_o=6'b000000.
REQ-046 Bench SHALL repeat REQ-045 with one payload bit flipped -> rx_status_o=6'b010000.
REQ-047 Bench SHALL drive a 60-byte broadcast frame with valid FCS and PRO=0 -> rx_len_o=60, rx_status_o=6'b000100.
REQ-048 Bench SHALL drive a 1600-byte frame with HUGEN=0, then again with HUGEN=1 -> too_long=1, then too_long=0; a 64-byte frame with DA mismatch -> addr_miss=1 with PRO=0 and addr_miss=0 with PRO=1.
REQ-049 Bench SHALL drive a valid frame plus one extra nibble -> dribble=1, crc_err=0, rx_len_o=64; MRxErr pulsed once mid-frame -> rx_err=1.
REQ-050 Bench SHALL pulse prstn_i low mid-frame while MRxDV stays high -> no rx_done_o for that frame; the next frame after MRxDV=0 SHALL be received normally.
